// File: rtl/test_seq.sv
// rtl/test_seq.sv - frame-size sweep sequencer driving a MAC traffic generator and scoring received frames
module test_seq #(
    parameter int PKT_CNT   = 16,
    parameter int SIZE_MIN  = 64,
    parameter int SIZE_MAX  = 1518,
    parameter int SIZE_STEP = 64,
    parameter int PAUSE     = 64,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        abort,
    input  logic        mac_tx_eof,
    input  logic        mac_tx_valid,
    input  logic        mac_rx_eof,
    input  logic        mac_rx_fr_good,
    input  logic        mac_rx_fr_err,
    input  logic        chk_err,
    output logic        gen_start,
    output logic [15:0] gen_pkt_size,
    output logic [15:0] gen_pause_size,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] fail_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [15:0] PKT_CNT_W   = 16'(PKT_CNT);
    localparam logic [15:0] SIZE_MIN_W  = 16'(SIZE_MIN);
    localparam logic [16:0] SIZE_MAX_W  = 17'(SIZE_MAX);
    localparam logic [16:0] SIZE_STEP_W = 17'(SIZE_STEP);
    localparam logic [15:0] PAUSE_W     = 16'(PAUSE);
    localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT);

    logic [2:0]  state, state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt;
    logic [15:0] idle_tmr, idle_tmr_nxt;
    logic [15:0] size_nxt, good_nxt, err_nxt, fail_nxt;
    logic        step_fail, step_fail_nxt;
    logic        tx_eof, rx_eof, active;
    logic [16:0] size_sum;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign tx_eof   = mac_tx_valid & mac_tx_eof;
    assign active   = (state == S_SEND) || (state == S_DRAIN);
    assign rx_eof   = active & mac_rx_eof;
    assign size_sum = {1'b0, gen_pkt_size} + SIZE_STEP_W;

    always_comb begin
        state_nxt     = state;
        tx_cnt_nxt    = tx_cnt;
        rx_cnt_nxt    = rx_cnt;
        idle_tmr_nxt  = idle_tmr;
        step_fail_nxt = step_fail;
        size_nxt      = gen_pkt_size;
        good_nxt      = good_cnt;
        err_nxt       = err_cnt;
        fail_nxt      = fail_cnt;
        case (state)
            S_IDLE, S_DONE: begin
                if (run) begin
                    state_nxt = S_ARM;
                    good_nxt  = 16'd0;
                    err_nxt   = 16'd0;
                    fail_nxt  = 16'd0;
                    size_nxt  = SIZE_MIN_W;
                end
            end
            S_ARM: begin
                tx_cnt_nxt    = 16'd0;
                rx_cnt_nxt    = 16'd0;
                idle_tmr_nxt  = 16'd0;
                step_fail_nxt = 1'b0;
                state_nxt     = S_SEND;
            end
            S_SEND, S_DRAIN: begin
                if (state == S_SEND && tx_eof)
                    tx_cnt_nxt = sat_inc(tx_cnt);
                // An errored frame is never also counted good, even if fr_good is set
                if (rx_eof) begin
                    rx_cnt_nxt = sat_inc(rx_cnt);
                    if (mac_rx_fr_err) begin
                        err_nxt       = sat_inc(err_cnt);
                        step_fail_nxt = 1'b1;
                    end else if (mac_rx_fr_good) begin
                        good_nxt = sat_inc(good_cnt);
                    end
                end
                if (chk_err)
                    step_fail_nxt = 1'b1;
                idle_tmr_nxt = (tx_eof || rx_eof) ? 16'd0 : sat_inc(idle_tmr);
                if (state == S_DRAIN && rx_cnt_nxt >= PKT_CNT_W) begin
                    state_nxt = S_NEXT;
                end else if (idle_tmr_nxt >= TIMEOUT_W) begin
                    step_fail_nxt = 1'b1;
                    state_nxt     = S_NEXT;
                end else if (state == S_SEND && tx_cnt_nxt >= PKT_CNT_W) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_NEXT: begin
                if (step_fail)
                    fail_nxt = sat_inc(fail_cnt);
                if (size_sum > SIZE_MAX_W) begin
                    state_nxt = S_DONE;
                end else begin
                    size_nxt  = size_sum[15:0];
                    state_nxt = S_ARM;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe
    always_ff @(posedge clk) begin
        gen_pause_size <= PAUSE_W;
        if (rst) begin
            state        <= S_IDLE;
            gen_start    <= 1'b0;
            gen_pkt_size <= SIZE_MIN_W;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            good_cnt     <= 16'd0;
            err_cnt      <= 16'd0;
            fail_cnt     <= 16'd0;
            tx_cnt       <= 16'd0;
            rx_cnt       <= 16'd0;
            idle_tmr     <= 16'd0;
            step_fail    <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            gen_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state        <= state_nxt;
            gen_start    <= (state_nxt == S_SEND);
            gen_pkt_size <= size_nxt;
            busy         <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done         <= (state_nxt == S_DONE);
            pass         <= (state_nxt == S_DONE) && (fail_nxt == 16'd0);
            good_cnt     <= good_nxt;
            err_cnt      <= err_nxt;
            fail_cnt     <= fail_nxt;
            tx_cnt       <= tx_cnt_nxt;
            rx_cnt       <= rx_cnt_nxt;
            idle_tmr     <= idle_tmr_nxt;
            step_fail    <= step_fail_nxt;
        end
    end

endmodule

// File: tb/tb_test_seq.sv
// tb/tb_test_seq.sv - directed bench for test_seq with a loopback generator model
module tb_test_seq;

    localparam int PKT_CNT   = 4;
    localparam int SIZE_MIN  = 64;
    localparam int SIZE_MAX  = 192;
    localparam int SIZE_STEP = 64;
    localparam int PAUSE     = 8;
    localparam int TIMEOUT   = 100;

    logic        clk = 1'b0;
    logic        rst, run, abort;
    logic        mac_tx_eof, mac_tx_valid, mac_rx_eof, mac_rx_fr_good, mac_rx_fr_err, chk_err;
    logic        gen_start, busy, done, pass;
    logic [15:0] gen_pkt_size, gen_pause_size, good_cnt, err_cnt, fail_cnt;

    int       n_tests = 0;
    int       n_fail  = 0;
    int       cyc = 0, ph = 0, tx_sent = 0, rx_sent = 0, eof_cyc = 0;
    logic [2:0] rx_pipe = 3'b000;
    bit       tx_en = 1, rx_en = 1, err_inject = 0, err_done = 0;

    always #5 clk = ~clk;

    test_seq #(
        .PKT_CNT(PKT_CNT), .SIZE_MIN(SIZE_MIN), .SIZE_MAX(SIZE_MAX),
        .SIZE_STEP(SIZE_STEP), .PAUSE(PAUSE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort),
        .mac_tx_eof(mac_tx_eof), .mac_tx_valid(mac_tx_valid),
        .mac_rx_eof(mac_rx_eof), .mac_rx_fr_good(mac_rx_fr_good),
        .mac_rx_fr_err(mac_rx_fr_err), .chk_err(chk_err),
        .gen_start(gen_start), .gen_pkt_size(gen_pkt_size),
        .gen_pause_size(gen_pause_size), .busy(busy), .done(done), .pass(pass),
        .good_cnt(good_cnt), .err_cnt(err_cnt), .fail_cnt(fail_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: 4-cycle frames every 8 cycles while gen_start, rx eof echoed 3 cycles later
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (gen_start && tx_en) begin
            mac_tx_valid = (ph < 4);
            mac_tx_eof   = (ph == 3);
            if (ph == 3) begin
                tx_sent++;
                eof_cyc = cyc + 1;
            end
            ph = (ph + 1) % 8;
        end else begin
            mac_tx_valid = 1'b0;
            mac_tx_eof   = 1'b0;
            ph           = 0;
        end
        mac_rx_eof     = rx_pipe[2];
        mac_rx_fr_good = rx_pipe[2];
        mac_rx_fr_err  = 1'b0;
        if (rx_pipe[2]) begin
            rx_sent++;
            if (err_inject && !err_done && gen_pkt_size == 16'd128) begin
                mac_rx_fr_err = 1'b1;
                err_done      = 1;
            end
        end
        rx_pipe = {rx_pipe[1:0], mac_tx_eof & rx_en};
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gen_start"}, gen_start, 0);
        check({tag, "_size"}, gen_pkt_size, SIZE_MIN);
        check({tag, "_pause"}, gen_pause_size, PAUSE);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_good"}, good_cnt, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_fail"}, fail_cnt, 0);
    endtask

    initial begin
        int hi;
        int prev_fail;
        int step_no;
        rst = 1; run = 0; abort = 0; chk_err = 0;
        mac_tx_eof = 0; mac_tx_valid = 0; mac_rx_eof = 0; mac_rx_fr_good = 0; mac_rx_fr_err = 0;
        repeat (3) tick();
        rst = 0;
        tick();
        check_reset_vals("rst");

        // Loopback: three sizes, all frames good
        run = 1; tick(); run = 0;
        check("arm_busy", busy, 1);
        check("arm_size", gen_pkt_size, 64);
        wait_done("lb_done", 2000);
        check("lb_good", good_cnt, 12);
        check("lb_err", err_cnt, 0);
        check("lb_fail", fail_cnt, 0);
        check("lb_pass", pass, 1);
        check("lb_busy", busy, 0);
        check("lb_size", gen_pkt_size, 192);
        repeat (4) tick();

        // One frame in step 2 flagged good and err at once
        err_inject = 1; err_done = 0;
        run = 1; tick(); run = 0;
        wait_done("er_done", 2000);
        err_inject = 0;
        check("er_err", err_cnt, 1);
        check("er_good", good_cnt, 11);
        check("er_fail", fail_cnt, 1);
        check("er_pass", pass, 0);
        repeat (4) tick();

        // Receive path silent: every step times out in DRAIN
        rx_en = 0;
        run = 1; tick(); run = 0;
        check("to_clr_fail", fail_cnt, 0);
        prev_fail = 0;
        step_no = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            if (fail_cnt != prev_fail[15:0]) begin
                step_no++;
                check($sformatf("to_delay%0d", step_no), cyc - eof_cyc, 101);
                check($sformatf("to_gen%0d", step_no), gen_start, 0);
                prev_fail = fail_cnt;
            end
        end
        check("to_done", done, 1);
        check("to_fail", fail_cnt, 3);
        check("to_good", good_cnt, 0);
        check("to_pass", pass, 0);

        // Generator silent: timeout inside SEND drops gen_start after TIMEOUT cycles
        tx_en = 0;
        run = 1; tick(); run = 0;
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (gen_start) hi++;
            else if (hi > 0) break;
        end
        check("send_to_hi", hi, 100);
        check("send_to_busy", busy, 1);
        abort = 1; tick(); abort = 0;
        check("send_to_abort_busy", busy, 0);
        tx_en = 1; rx_en = 1;
        repeat (4) tick();

        // Abort in the middle of step 2
        rx_sent = 0;
        run = 1; tick(); run = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (mac_rx_eof && rx_sent == 6) break;
        end
        tick();
        check("ab_pre_gen", gen_start, 1);
        abort = 1; tick(); abort = 0;
        check("ab_gen", gen_start, 0);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_good", good_cnt, 6);
        check("ab_size", gen_pkt_size, 128);
        repeat (3) tick();
        check("ab_idle_gen", gen_start, 0);
        run = 1; tick(); run = 0;
        check("rerun_good", good_cnt, 0);
        check("rerun_size", gen_pkt_size, 64);
        check("rerun_busy", busy, 1);
        abort = 1; tick(); abort = 0;
        repeat (6) tick();

        // Reset while draining the first step
        tx_sent = 0;
        run = 1; tick(); run = 0;
        for (int i = 0; i < 500 && tx_sent < 4; i++) tick();
        tick();
        check("dr_gen", gen_start, 0);
        check("dr_busy", busy, 1);
        check("dr_good", good_cnt, 3);
        rst = 1; tick(); rst = 0;
        check_reset_vals("dr_rst");
        repeat (6) tick();
        check("dr_post_good", good_cnt, 0);
        check("dr_post_gen", gen_start, 0);
        check("dr_post_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/test_seq.md
TEST_SEQ -- requirements
Module: test_seq

Interface
REQ-001 Parameter PKT_CNT, default 16: frames sent per size step (1..65535).
REQ-002 Parameter SIZE_MIN, default 64: first step frame size in bytes.
REQ-003 Parameter SIZE_MAX, default 1518: last allowed frame size in bytes.
REQ-004 Parameter SIZE_STEP, default 64: size increment between steps (>=1).
REQ-005 Parameter PAUSE, default 64: inter-frame pause in cycles (>=2).
REQ-006 Parameter TIMEOUT, default 65535: idle-cycle limit per step (16-bit).
REQ-007 clk  in  1  sole clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 run  in  1  start pulse; sampled only in IDLE or DONE.
REQ-010 abort  in  1  stop request; return to IDLE.
REQ-011 mac_tx_eof  in  1  generator end-of-frame strobe (qualified by mac_tx_valid).
REQ-012 mac_tx_valid  in  1  generator byte valid.
REQ-013 mac_rx_eof  in  1  receive end-of-frame strobe.
REQ-014 mac_rx_fr_good  in  1  frame good, valid with mac_rx_eof.
REQ-015 mac_rx_fr_err  in  1  frame error, valid with mac_rx_eof.
REQ-016 chk_err  in  1  payload checker error level.
REQ-017 gen_start  out  1  generator enable level.
REQ-018 gen_pkt_size  out  16  current frame size.
REQ-019 gen_pause_size  out  16  constant PAUSE.
REQ-020 busy  out  1  high in any state except IDLE and DONE.
REQ-021 done  out  1  high in DONE.
REQ-022 pass  out  1  high in DONE when fail_cnt==0.
REQ-023 good_cnt  out  16  good frames received this run.
REQ-024 err_cnt  out  16  errored frames received this run.
REQ-025 fail_cnt  out  16  failed steps this run.

Function
REQ-026 FSM states IDLE, ARM, SEND, DRAIN, NEXT, DONE; all outputs registered.
REQ-027 IDLE/DONE + run=1 -> ARM next cycle; counters cleared, gen_pkt_size=SIZE_MIN.
REQ-028 ARM: clear step tx_cnt, rx_cnt, step_fail, idle timer; -> SEND after one cycle.
REQ-029 SEND: gen_start=1; each mac_tx_valid&mac_tx_eof increments tx_cnt; at tx_cnt reaching PKT_CNT -> DRAIN, gen_start=0 from the following cycle.
REQ-030 Any mac_rx_eof increments rx_cnt (states SEND, DRAIN); with fr_err=1 increments err_cnt and sets step_fail; else with fr_good=1 increments good_cnt; fr_good&fr_err counts as err only.
REQ-031 chk_err=1 in SEND or DRAIN sets step_fail.
REQ-032 DRAIN: rx_cnt>=PKT_CNT -> NEXT.
REQ-033 Idle timer: cleared on any tx or rx eof, else increments in SEND/DRAIN; reaching TIMEOUT sets step_fail, gen_start=0, -> NEXT.
REQ-034 NEXT: fail_cnt += step_fail; if gen_pkt_size+SIZE_STEP > SIZE_MAX (17-bit compare) -> DONE, else gen_pkt_size += SIZE_STEP, -> ARM.
REQ-035 DONE: hold counters, done=1, pass=(fail_cnt==0); run restarts per REQ-027.
REQ-036 All counters saturate at 16'hFFFF, no wrap.
REQ-037 abort=1 in any state -> IDLE next cycle, gen_start=0; counters retained; abort overrides run.
REQ-038 Simultaneous tx eof and rx eof in one cycle: both counted.
REQ-039 mac_rx_eof in IDLE, ARM, NEXT or DONE: ignored.

Reset
REQ-040 rst=1: state IDLE, gen_start=0, gen_pkt_size=SIZE_MIN, gen_pause_size=PAUSE, busy=done=pass=0, all counters 0; rst overrides run/abort; mid-run reset aborts with no further frames started.

Verification
REQ-041 Loopback tx->rx, PKT_CNT=4, sizes 64..192 step 64: 3 steps, good_cnt=12, err_cnt=0, fail_cnt=0, done=pass=1.
REQ-042 One rx eof with fr_err=1 in step 2: err_cnt=1, good_cnt=11, fail_cnt=1, pass=0.
REQ-043 rx silent, TIMEOUT=100: each step ends 100 cycles after last tx eof, fail_cnt=3, gen_start low on timeout.
REQ-044 abort mid-SEND: gen_start=0 next cycle, IDLE, busy=0; new run pulse clears counters and restarts at 64.
REQ-045 rst asserted during DRAIN: all outputs at reset values next cycle; fr_good and fr_err both high on one eof counts err only.
